imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the instruction memory read port.
- Accepts a byte stream from a host link (UART RX or debug bridge) using a valid/ready handshake.
- Assembles the bytes into 32-bit little-endian instruction words and drives the memory write port (wren/wr_address/wr_data) at consecutive word addresses starting at 0.
- Holds the processor via cpu_hold from the start of a load until the image is complete.

Parameters:
- ADDR_WIDTH, 8, width of word address to the instruction memory.
- DEPTH, 256, number of 32-bit words in the instruction memory; maximum legal image size.

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load; ignored unless in IDLE, DONE or ERROR.
- byte_valid  input  1  host byte available.
- byte_data  input  8  host byte.
- byte_ready  output  1  loader accepts byte this cycle; a transfer occurs when byte_valid && byte_ready.
- wren  output  1  instruction memory write enable, one cycle per word.
- wr_address  output  ADDR_WIDTH  word address of the current write.
- wr_data  output  32  instruction word to write.
- cpu_hold  output  1  high while loading or in error; processor is held in reset.
- done  output  1  one-cycle pulse when the last word has been written.
- error  output  1  sticky error flag; cleared by start or reset.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; byte_ready=0, wren=0, wr_address=0, wr_data=0, cpu_hold=0, done=0, error=0; byte counter, word counter and length register all 0. Memory contents are not touched. A reset mid-load abandons the load; any partially written words remain in memory.
- States:
  - IDLE: byte_ready=0. On start -> LEN; cpu_hold=1, error=0, wr_address=0.
  - LEN: byte_ready=1. On transfer, store L=byte_data; word count N=L+1 (range 1..256).
    - If N>DEPTH -> ERROR.
    - Otherwise -> DATA.
  - DATA: byte_ready=1. Bytes are packed little-endian: 1st byte -> wr_data[7:0], 4th -> [31:24]. On the 4th transfer -> WRITE.
  - WRITE: exactly one cycle. byte_ready=0, wren=1, wr_data holds the assembled word, wr_address = current word index.
    - Next cycle: wren=0 and wr_address increments.
    - If the word just written was word N-1 -> FIN; otherwise -> DATA.
  - FIN: done=1 for one cycle, cpu_hold=0 -> DONE.
  - DONE: idle-equivalent. wr_address holds N. start begins a new load.
  - ERROR: byte_ready=0, error=1, cpu_hold=1. Only start or reset leaves this state; start -> LEN.
- Latency:
  - wren asserts the cycle after the 4th byte of a word is accepted.
  - Minimum load time = 1 + 5N cycles after start plus host stalls, then 1 cycle for done.
- Handshake:
  - byte_valid may drop at any time; no byte is lost or duplicated.
  - byte_data is sampled only on a transfer.
  - byte_ready does not depend combinationally on byte_valid.
- start outside IDLE/DONE/ERROR is ignored.
- start and a transfer in the same cycle in LEN/DATA: start is ignored and the transfer completes.
- Wrap-around: with DEPTH=256 and L=255, wr_address reaches 255 on the last write. The post-increment wraps to 0 in an ADDR_WIDTH-bit register; DONE reports no address.
- done and error are never high in the same cycle.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After word N-1 is written, state CSUM (byte_ready=1) accepts one extra byte.
  - That byte must equal the XOR of all 4N data bytes (length byte excluded).
  - Match -> FIN.
  - Mismatch -> ERROR: error=1, cpu_hold stays 1, no done pulse.
  - Running XOR clears on start and reset.
- When undefined: no CSUM state and no checksum logic; after the last WRITE the loader goes directly to FIN.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; byte_ready=0.
- start; bytes 0x01, 13 00 00 00, 93 00 10 00 with byte_valid continuously high -> wren pulses at address 0 with wr_data=0x00000013 and at address 1 with wr_data=0x00100093; done pulses once; cpu_hold 1→0 the same cycle done rises.
- Same image with byte_valid toggling every other cycle, plus start pulses issued mid-load -> identical writes and data, no extra wren, start ignored.
- DEPTH=4 build; start; length byte 0x04 (N=5) -> ERROR: error=1, cpu_hold=1, byte_ready=0, no wren. A new start clears error, and a valid image then loads.
- Reset asserted after the 2nd byte of word 1 -> next cycle all outputs at reset values; a new start writes word 0 at address 0 again.
- IMEM_LOADER_CHECKSUM_EN: image 0x00, 13 00 00 00, checksum byte 0x13 -> done. Same image with checksum byte 0x12 -> error=1 and no done; the wren for word 0 still occurred.

Source files
------------

// File: rtl/imem_loader.sv
// Host byte-stream loader for the instruction memory write port: assembles little-endian words
// and holds the CPU while loading. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wren,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd7;
`endif

    localparam logic [9:0] DEPTH_W = 10'(DEPTH);

    logic [2:0] state;
    logic [1:0] byte_cnt;
    logic [8:0] word_cnt;
    logic [7:0] len_reg;
    logic       xfer;
    logic       last_word;
    logic [9:0] n_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    // Handshake and status outputs decode the state register only, so ready never depends on valid.
    always_comb begin
        byte_ready = (state == S_LEN) || (state == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_ready = byte_ready || (state == S_CSUM);
`endif
        wren     = (state == S_WRITE);
        done     = (state == S_FIN);
        error    = (state == S_ERROR);
        cpu_hold = (state != S_IDLE) && (state != S_FIN) && (state != S_DONE);
    end

    assign xfer      = byte_valid && byte_ready;
    assign last_word = (word_cnt == {1'b0, len_reg});
    assign n_words   = {2'b00, byte_data} + 10'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            byte_cnt   <= 2'd0;
            word_cnt   <= 9'd0;
            len_reg    <= 8'd0;
            wr_address <= '0;
            wr_data    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state      <= S_LEN;
                        byte_cnt   <= 2'd0;
                        word_cnt   <= 9'd0;
                        wr_address <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= 8'd0;
`endif
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        len_reg <= byte_data;
                        state   <= (n_words > DEPTH_W) ? S_ERROR : S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        wr_data[{byte_cnt, 3'b000} +: 8] <= byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // Address wraps naturally at the last word of a full-depth image.
                    wr_address <= wr_address + ADDR_WIDTH'(1);
                    word_cnt   <= word_cnt + 9'd1;
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= S_CSUM;
`else
                        state <= S_FIN;
`endif
                    end else begin
                        state <= S_DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer) begin
                        state <= (byte_data == csum) ? S_FIN : S_ERROR;
                    end
                end
`endif
                S_FIN: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a full-depth instance and a DEPTH=4 instance,
// each checked against image-level expectations (write list, done/error outcome, load timing).
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        start_s      [2];
    logic        byte_valid_s [2];
    logic [7:0]  byte_data_s  [2];
    logic        byte_ready_s [2];
    logic        wren_s       [2];
    logic [7:0]  wr_address_s [2];
    logic [31:0] wr_data_s    [2];
    logic        cpu_hold_s   [2];
    logic        done_s       [2];
    logic        error_s      [2];

    imem_loader #(.ADDR_WIDTH(8), .DEPTH(256)) dut_full (
        .clock(clock), .reset(reset), .start(start_s[0]),
        .byte_valid(byte_valid_s[0]), .byte_data(byte_data_s[0]), .byte_ready(byte_ready_s[0]),
        .wren(wren_s[0]), .wr_address(wr_address_s[0]), .wr_data(wr_data_s[0]),
        .cpu_hold(cpu_hold_s[0]), .done(done_s[0]), .error(error_s[0])
    );

    imem_loader #(.ADDR_WIDTH(8), .DEPTH(4)) dut_small (
        .clock(clock), .reset(reset), .start(start_s[1]),
        .byte_valid(byte_valid_s[1]), .byte_data(byte_data_s[1]), .byte_ready(byte_ready_s[1]),
        .wren(wren_s[1]), .wr_address(wr_address_s[1]), .wr_data(wr_data_s[1]),
        .cpu_hold(cpu_hold_s[1]), .done(done_s[1]), .error(error_s[1])
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
    bit csum_bad = 0;
`else
    localparam int CS = 0;
`endif

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          wcnt [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          done_cyc [2] = '{0, 0};
    logic        hold_at_done [2];
    int          both_hi = 0;
    logic [7:0]  waddr_log [2][1024];
    logic [31:0] wdata_log [2][1024];
    logic [31:0] img [256];
    int          depth_of [2] = '{256, 4};

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Observed write/done history of both instances, sampled mid-cycle.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (wren_s[k]) begin
                if (wcnt[k] < 1024) begin
                    waddr_log[k][wcnt[k]] = wr_address_s[k];
                    wdata_log[k][wcnt[k]] = wr_data_s[k];
                end
                wcnt[k]++;
            end
            if (done_s[k]) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
                hold_at_done[k] = cpu_hold_s[k];
            end
            if (done_s[k] && error_s[k]) both_hi++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int k);
        @(negedge clock);
        start_s[k] = 1'b1;
        @(negedge clock);
        start_s[k] = 1'b0;
        start_cyc = cyc;
    endtask

    // mode 0: valid always high; 1: valid every other cycle plus stray starts; 2: random valid plus stray starts
    task automatic send(input int k, input logic [7:0] b[$], input int mode);
        int i = 0;
        int guard = 0;
        logic v;
        while (i < b.size() && guard < 4000) begin
            @(negedge clock);
            guard++;
            case (mode)
                0: v = 1'b1;
                1: v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            byte_valid_s[k] = v;
            byte_data_s[k]  = v ? b[i] : 8'($urandom);
            start_s[k]      = (mode != 0) && ($urandom_range(0, 3) == 0);
            if (v && byte_ready_s[k]) i++;
        end
        chk("bytes_accepted", i, b.size());
        @(negedge clock);
        byte_valid_s[k] = 1'b0;
        start_s[k]      = 1'b0;
    endtask

    task automatic do_load(input int k, input int n, input int mode);
        logic [7:0] q[$];
        int w0, d0, g, nw;
        bit exp_err;
        w0 = wcnt[k];
        d0 = done_cnt[k];
        exp_err = (n > depth_of[k]);
        q.push_back(8'(n - 1));
        if (!exp_err) begin
            for (int i = 0; i < n; i++)
                for (int b = 0; b < 4; b++) q.push_back(img[i][8*b +: 8]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!exp_err) begin
            logic [7:0] x = 8'd0;
            for (int i = 1; i < q.size(); i++) x ^= q[i];
            q.push_back(csum_bad ? (x ^ 8'h01) : x);
            exp_err = csum_bad;
        end
`endif
        pulse_start(k);
        chk("error_clear_on_start", error_s[k], 1'b0);
        chk("hold_on_start", cpu_hold_s[k], 1'b1);
        send(k, q, mode);
        g = 0;
        while (done_cnt[k] == d0 && !error_s[k] && g < 100) begin
            @(negedge clock);
            g++;
        end
        chk("load_finished", (g < 100), 1'b1);
        repeat (2) @(negedge clock);
        if (exp_err) begin
            chk("err_flag", error_s[k], 1'b1);
            chk("err_hold", cpu_hold_s[k], 1'b1);
            chk("err_ready", byte_ready_s[k], 1'b0);
            chk("err_no_done", done_cnt[k] - d0, 0);
            chk("err_writes", wcnt[k] - w0, (n > depth_of[k]) ? 0 : n);
        end else begin
            chk("done_once", done_cnt[k] - d0, 1);
            chk("hold_at_done", hold_at_done[k], 1'b0);
            chk("hold_after", cpu_hold_s[k], 1'b0);
            chk("error_after", error_s[k], 1'b0);
            chk("addr_after", wr_address_s[k], n % 256);
            chk("write_count", wcnt[k] - w0, n);
            if (mode == 0) chk("done_time", done_cyc[k] - start_cyc, 2 + 5 * n + CS);
            nw = (wcnt[k] - w0 < n) ? (wcnt[k] - w0) : n;
            for (int i = 0; i < nw; i++) begin
                chk("wr_addr", waddr_log[k][w0 + i], i % 256);
                chk("wr_data", wdata_log[k][w0 + i], img[i]);
            end
        end
    endtask

    initial begin
        logic [7:0] q[$];
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            byte_valid_s[k] = 1'b0;
            byte_data_s[k] = 8'd0;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("rst_ready", byte_ready_s[0], 1'b0);
        chk("rst_wren", wren_s[0], 1'b0);
        chk("rst_addr", wr_address_s[0], 0);
        chk("rst_data", wr_data_s[0], 0);
        chk("rst_hold", cpu_hold_s[0], 1'b0);
        chk("rst_done", done_s[0], 1'b0);
        chk("rst_error", error_s[0], 1'b0);
        chk("rst_ready_small", byte_ready_s[1], 1'b0);

        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        do_load(0, 2, 0);
        do_load(0, 2, 1);

        // Oversized image on the DEPTH=4 instance, then recovery and boundary-size loads.
        do_load(1, 5, 0);
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        do_load(1, 4, 2);
        do_load(1, 1, 0);

        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) img[i] = $urandom;
            do_load(0, n, t % 3);
        end
        for (int i = 0; i < 256; i++) img[i] = $urandom;
        do_load(0, 256, 0);

        // Reset in the middle of word 1, after two of its bytes.
        img[0] = 32'hA1B2_C3D4;
        img[1] = 32'h5566_7788;
        pulse_start(0);
        q = '{8'd1, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h88, 8'h77};
        send(0, q, 0);
        chk("midload_ready", byte_ready_s[0], 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk("mrst_ready", byte_ready_s[0], 1'b0);
        chk("mrst_wren", wren_s[0], 1'b0);
        chk("mrst_addr", wr_address_s[0], 0);
        chk("mrst_data", wr_data_s[0], 0);
        chk("mrst_hold", cpu_hold_s[0], 1'b0);
        chk("mrst_done", done_s[0], 1'b0);
        chk("mrst_error", error_s[0], 1'b0);
        reset = 1'b0;
        do_load(0, 2, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img[0] = 32'h0000_0013;
        csum_bad = 0;
        do_load(0, 1, 0);
        csum_bad = 1;
        do_load(0, 1, 0);
        csum_bad = 0;
        do_load(0, 1, 1);
`endif

        chk("done_error_overlap", both_hi, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
